passcode_verifier: RTL
======================

PASSCODE_VERIFIER -- requirements
Module: passcode_verifier

Interface
REQ-001 Parameter MAX_DIGITS, default 6, SHALL set the entry and stored buffer depth in BCD digits (range 4..16).
REQ-002 Parameter MIN_DIGITS, default 4, SHALL set the minimum length of a programmable passcode.
REQ-003 Parameter MAX_FAILS, default 3, SHALL set the consecutive failed compares that trigger lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 1024, SHALL set the lockout duration in clk cycles.
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 digit_valid  input  1  qualifies digit for one cycle.
REQ-008 digit  input  4  BCD digit, 0..9.
REQ-009 enter  input  1  one-cycle compare request (star key).
REQ-010 clear  input  1  one-cycle entry-buffer flush.
REQ-011 program  input  1  sampled with enter in OPEN: store entry as new passcode.
REQ-012 digit_count  output  $clog2(MAX_DIGITS+1)  digits currently in the entry buffer.
REQ-013 unlocked  output  1  high while in OPEN.
REQ-014 match_pulse / fail_pulse / prog_done  output  1 each  one-cycle result strobes.
REQ-015 locked  output  1  high while in LOCKOUT.

Function
REQ-016 The FSM SHALL have states ENTRY, COMPARE, OPEN, LOCKOUT.
REQ-017 ENTRY/OPEN: digit_valid with digit<=9 and digit_count<MAX_DIGITS SHALL append the digit and increment digit_count; digit>9 or a full buffer SHALL be ignored without a state change.
REQ-018 clear SHALL empty the entry buffer (digit_count=0) on the next edge; clear wins over enter and digit_valid in the same cycle.
REQ-019 enter wins over digit_valid in the same cycle; the simultaneous digit is dropped.
REQ-020 ENTRY + enter SHALL go to COMPARE for exactly one cycle.
REQ-021 COMPARE: match requires digit_count equal to the stored length and all stored digits equal; no partial or prefix match.
REQ-022 Match SHALL go to OPEN, clear the fail counter, and raise match_pulse for one cycle, two edges after the edge that sampled enter.
REQ-023 Mismatch SHALL increment the fail counter and raise fail_pulse with the same latency; reaching MAX_FAILS SHALL go to LOCKOUT, otherwise to ENTRY.
REQ-024 Leaving COMPARE SHALL empty the entry buffer.
REQ-025 OPEN + enter with program=1 and MIN_DIGITS<=digit_count SHALL copy the entry to storage, raise prog_done next cycle, and go to ENTRY.
REQ-026 OPEN + enter with program=1 and digit_count<MIN_DIGITS SHALL leave storage unchanged, raise fail_pulse without counting, and stay in OPEN.
REQ-027 OPEN + enter with program=0 SHALL relock to ENTRY.
REQ-028 LOCKOUT SHALL ignore all inputs, count LOCKOUT_CYCLES cycles, then go to ENTRY with the fail counter cleared.

Reset
REQ-029 reset SHALL force ENTRY, empty the entry buffer, zero the fail and lockout counters, and drive every output low.
REQ-030 reset SHALL load the stored passcode with 0,0,0,0 (length 4); a reset mid-lockout or mid-OPEN SHALL abandon that state immediately.

Configuration
REQ-031 With LOCKOUT_EN defined, REQ-023/REQ-028 lockout SHALL be built in.
REQ-032 Without LOCKOUT_EN, the fail and lockout counters SHALL be absent, locked SHALL be tied 0, and every mismatch SHALL return to ENTRY.

Structure
REQ-033 Package passcode_pkg SHALL hold the state enum, BCD_W=4, BCD_MAX=9 and the default passcode constant.
REQ-034 Sub-module passcode_digit_buf SHALL implement one MAX_DIGITS x 4 buffer with a length field, instanced for entry and storage.

Verification
REQ-035 Out of reset, enter 0,0,0,0 then enter -> match_pulse 2 edges after enter, unlocked=1.
REQ-036 In OPEN, enter 1,2,3,4,5 and enter with program=1 -> prog_done=1; 0,0,0,0+enter -> fail_pulse; 1,2,3,4,5+enter -> match_pulse.
REQ-037 Stored 1,2,3,4,5: inputs 1,2,3,4 then enter, and 1,2,3,4,5,6 then enter -> fail_pulse both times (no prefix match); digit 0xA ignored, digit_count unchanged.
REQ-038 Three wrong compares -> locked=1 for 1024 cycles, digits/enter ignored, then locked=0 and correct code matches.
REQ-039 clear and enter asserted together after 3 digits -> digit_count=0, no pulse, state ENTRY.
REQ-040 reset asserted during LOCKOUT -> locked=0 asynchronously; stored code reverts to 0,0,0,0.

Source files
------------

// File: rtl/passcode_pkg.sv
// rtl/passcode_pkg.sv - shared types and constants for the passcode verifier
package passcode_pkg;
  localparam int               BCD_W     = 4;
  localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
  localparam int               DEF_LEN   = 4;
  localparam logic [BCD_W-1:0] DEF_DIGIT = '0;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_COMPARE,
    ST_OPEN,
    ST_LOCKOUT
  } state_e;
endpackage

// File: rtl/passcode_verifier_if.sv
// rtl/passcode_verifier_if.sv - keypad input and result strobe bundle
interface passcode_verifier_if
  import passcode_pkg::*;
#(
  parameter int MAX_DIGITS = 6
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic             digit_valid;
  logic [BCD_W-1:0] digit;
  logic             enter;
  logic             clear;
  logic             program_en;
  logic [CW-1:0]    digit_count;
  logic             unlocked;
  logic             match_pulse;
  logic             fail_pulse;
  logic             prog_done;
  logic             locked;

  modport master (
    output digit_valid, digit, enter, clear, program_en,
    input  digit_count, unlocked, match_pulse, fail_pulse, prog_done, locked
  );

  modport slave (
    input  digit_valid, digit, enter, clear, program_en,
    output digit_count, unlocked, match_pulse, fail_pulse, prog_done, locked
  );
endinterface

// File: rtl/passcode_digit_buf.sv
// rtl/passcode_digit_buf.sv - MAX_DIGITS x BCD digit buffer with length field
module passcode_digit_buf
  import passcode_pkg::*;
#(
  parameter int  MAX_DIGITS = 6,
  parameter int  RST_LEN    = 0,
  localparam int CW         = $clog2(MAX_DIGITS + 1),
  localparam int DW         = MAX_DIGITS * BCD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [BCD_W-1:0] push_digit,
  input  logic             load,
  input  logic [DW-1:0]    load_data,
  input  logic [CW-1:0]    load_len,
  output logic [DW-1:0]    data,
  output logic [CW-1:0]    len
);
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] len_q, len_d;

  // Clearing only drops the length; stale digits beyond len are never read.
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (load) begin
      data_d = load_data;
      len_d  = load_len;
    end else if (clr) begin
      len_d = '0;
    end else if (push) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        if (CW'(i) == len_q) data_d[i*BCD_W +: BCD_W] = push_digit;
      end
      len_d = len_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= {MAX_DIGITS{DEF_DIGIT}};
      len_q  <= CW'(RST_LEN);
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
    end
  end

  assign data = data_q;
  assign len  = len_q;
endmodule

// File: rtl/passcode_verifier.sv
// rtl/passcode_verifier.sv - keypad passcode verifier FSM with programmable code
// Define LOCKOUT_EN to build the consecutive-failure lockout.
module passcode_verifier
  import passcode_pkg::*;
#(
  parameter int MAX_DIGITS     = 6,
  parameter int MIN_DIGITS     = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  passcode_verifier_if.slave   bus
);
  localparam int            CW       = $clog2(MAX_DIGITS + 1);
  localparam int            DW       = MAX_DIGITS * BCD_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_DIGITS);

  state_e        state_q, state_d;
  logic          match_pend_q, match_pend_d;
  logic          fail_pend_q, fail_pend_d;
  logic          match_pulse_q, match_pulse_d;
  logic          fail_pulse_q, fail_pulse_d;
  logic          prog_done_q, prog_done_d;
  logic          ent_clr, ent_push, sto_load, digit_ok, code_match;
  logic [DW-1:0] ent_data, sto_data;
  logic [CW-1:0] ent_len, sto_len;

`ifdef LOCKOUT_EN
  localparam int            FW        = $clog2(MAX_FAILS + 1);
  localparam int            LW        = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = MAX_FAILS ^ LOCKOUT_CYCLES;
`endif

  passcode_digit_buf #(.MAX_DIGITS(MAX_DIGITS), .RST_LEN(0)) u_entry (
    .clk        (clk),
    .reset      (reset),
    .clr        (ent_clr),
    .push       (ent_push),
    .push_digit (bus.digit),
    .load       (1'b0),
    .load_data  ('0),
    .load_len   ('0),
    .data       (ent_data),
    .len        (ent_len)
  );

  passcode_digit_buf #(.MAX_DIGITS(MAX_DIGITS), .RST_LEN(DEF_LEN)) u_store (
    .clk        (clk),
    .reset      (reset),
    .clr        (1'b0),
    .push       (1'b0),
    .push_digit ('0),
    .load       (sto_load),
    .load_data  (ent_data),
    .load_len   (ent_len),
    .data       (sto_data),
    .len        (sto_len)
  );

  // Exact-length match: only positions below the entered length are compared.
  always_comb begin
    code_match = (ent_len == sto_len);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (CW'(i) < ent_len && ent_data[i*BCD_W +: BCD_W] != sto_data[i*BCD_W +: BCD_W])
        code_match = 1'b0;
    end
  end

  assign digit_ok = bus.digit_valid && (bus.digit <= BCD_MAX) && (ent_len < FULL_CNT);

  always_comb begin
    state_d       = state_q;
    ent_clr       = 1'b0;
    ent_push      = 1'b0;
    sto_load      = 1'b0;
    match_pend_d  = 1'b0;
    fail_pend_d   = 1'b0;
    match_pulse_d = match_pend_q;
    fail_pulse_d  = fail_pend_q;
    prog_done_d   = 1'b0;
`ifdef LOCKOUT_EN
    fail_cnt_d    = fail_cnt_q;
    lock_cnt_d    = lock_cnt_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (bus.clear)      ent_clr  = 1'b1;
        else if (bus.enter) state_d  = ST_COMPARE;
        else if (digit_ok)  ent_push = 1'b1;
      end
      ST_COMPARE: begin
        ent_clr = 1'b1;
        if (code_match) begin
          state_d      = ST_OPEN;
          match_pend_d = 1'b1;
`ifdef LOCKOUT_EN
          fail_cnt_d   = '0;
`endif
        end else begin
          fail_pend_d = 1'b1;
          state_d     = ST_ENTRY;
`ifdef LOCKOUT_EN
          fail_cnt_d  = fail_cnt_q + 1'b1;
          if (fail_cnt_q + 1'b1 >= FAIL_LIM) begin
            state_d    = ST_LOCKOUT;
            lock_cnt_d = '0;
          end
`endif
        end
      end
      ST_OPEN: begin
        if (bus.clear) begin
          ent_clr = 1'b1;
        end else if (bus.enter) begin
          ent_clr = 1'b1;
          if (!bus.program_en) begin
            state_d = ST_ENTRY;
          end else if (ent_len >= MIN_CNT) begin
            sto_load    = 1'b1;
            prog_done_d = 1'b1;
            state_d     = ST_ENTRY;
          end else begin
            fail_pulse_d = 1'b1;
          end
        end else if (digit_ok) begin
          ent_push = 1'b1;
        end
      end
      ST_LOCKOUT: begin
`ifdef LOCKOUT_EN
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_ENTRY;
          fail_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
`else
        state_d = ST_ENTRY;
`endif
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ENTRY;
      match_pend_q  <= 1'b0;
      fail_pend_q   <= 1'b0;
      match_pulse_q <= 1'b0;
      fail_pulse_q  <= 1'b0;
      prog_done_q   <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt_q    <= '0;
      lock_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      match_pend_q  <= match_pend_d;
      fail_pend_q   <= fail_pend_d;
      match_pulse_q <= match_pulse_d;
      fail_pulse_q  <= fail_pulse_d;
      prog_done_q   <= prog_done_d;
`ifdef LOCKOUT_EN
      fail_cnt_q    <= fail_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
`endif
    end
  end

  assign bus.digit_count = ent_len;
  assign bus.unlocked    = (state_q == ST_OPEN);
  assign bus.match_pulse = match_pulse_q;
  assign bus.fail_pulse  = fail_pulse_q;
  assign bus.prog_done   = prog_done_q;
`ifdef LOCKOUT_EN
  assign bus.locked      = (state_q == ST_LOCKOUT);
`else
  assign bus.locked      = 1'b0;
`endif
endmodule
